// File: rtl/nnrv_pkg.sv
// Shared defaults and the clear-sequencer state type for the nnrv_ram slice.
package nnrv_pkg;

   localparam int unsigned NNRV_DATA_WIDTH = 64;
   localparam int unsigned NNRV_XLEN       = 64;
   localparam int unsigned NNRV_MASK_WIDTH = NNRV_DATA_WIDTH >> 3;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } clr_state_e;

endpackage

// File: rtl/nnrv_ram_clr.sv
// Post-reset clear sequencer: zeroes one word per cycle, then idles in READY.
// Only compiled when NNRV_RAM_CLEAR_EN is defined.
`ifdef NNRV_RAM_CLEAR_EN
module nnrv_ram_clr
   import nnrv_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 12
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   output logic                  o_busy,
   output logic [DEPTH_LOG2-1:0] o_clr_addr,
   output logic                  o_clr_we
);

   localparam logic [DEPTH_LOG2-1:0] CNT_LAST = '1;
   localparam logic [DEPTH_LOG2-1:0] CNT_ONE  = DEPTH_LOG2'(1);

   clr_state_e            state_q, state_d;
   logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CLEAR: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) state_d = READY;
         end
         READY: state_d = READY;
         default: state_d = state_q;
      endcase
   end

   always_comb begin
      o_busy     = (state_q == CLEAR);
      o_clr_we   = (state_q == CLEAR);
      o_clr_addr = cnt_q;
   end

endmodule
`endif

// File: rtl/nnrv_ram.sv
// Byte-masked word RAM with combinational read, sticky range error and an
// optional post-reset zero clear enabled by NNRV_RAM_CLEAR_EN.
module nnrv_ram
   import nnrv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = NNRV_DATA_WIDTH,
   parameter int unsigned MASK_WIDTH = DATA_WIDTH >> 3,
   parameter int unsigned XLEN       = NNRV_XLEN,
   parameter int unsigned DEPTH_LOG2 = 12
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [XLEN-1:0]       i_rd_addr,
   input  logic                  i_rd_en,
   input  logic [MASK_WIDTH-1:0] i_rd_mask,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   input  logic [XLEN-1:0]       i_wr_addr,
   input  logic                  i_wr_en,
   input  logic [MASK_WIDTH-1:0] i_wr_mask,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   output logic                  o_busy,
   output logic                  o_err
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   function automatic logic [DATA_WIDTH-1:0] lane_bits(input logic [MASK_WIDTH-1:0] m);
      logic [DATA_WIDTH-1:0] b;
      b = '0;
      for (int l = 0; l < MASK_WIDTH; l++) b[l*8 +: 8] = {8{m[l]}};
      return b;
   endfunction

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DEPTH_LOG2-1:0] rd_idx, wr_idx, mem_idx, clr_addr;
   logic                  rd_in_range, wr_in_range, wr_commit, mem_we;
   logic                  busy, clr_we, err_q, err_d;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^{i_rd_addr[2:0], i_wr_addr[2:0]};

`ifdef NNRV_RAM_CLEAR_EN
   nnrv_ram_clr #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_clr (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .o_busy     (busy),
      .o_clr_addr (clr_addr),
      .o_clr_we   (clr_we)
   );
`else
   assign busy     = 1'b0;
   assign clr_addr = '0;
   assign clr_we   = 1'b0;
`endif

   always_comb begin
      rd_in_range = (i_rd_addr[XLEN-1:DEPTH_LOG2+3] == '0);
      wr_in_range = (i_wr_addr[XLEN-1:DEPTH_LOG2+3] == '0);
      rd_idx      = i_rd_addr[DEPTH_LOG2+2:3];
      wr_idx      = i_wr_addr[DEPTH_LOG2+2:3];
      rd_word     = mem_q[rd_idx];
      o_rd_data   = (i_rd_en && rd_in_range && !busy) ? (rd_word & lane_bits(i_rd_mask)) : '0;

      // Writes are merged into the old word so only enabled lanes change.
      wr_commit = i_wr_en && wr_in_range && !busy;
      mem_we    = clr_we || wr_commit;
      mem_idx   = clr_we ? clr_addr : wr_idx;
      mem_d     = clr_we ? '0 :
                  ((mem_q[wr_idx] & ~lane_bits(i_wr_mask)) | (i_wr_data & lane_bits(i_wr_mask)));

      // Writes dropped during clear are silent; out-of-range reads always flag.
      err_d = err_q || (i_rd_en && !rd_in_range) || (i_wr_en && !wr_in_range && !busy);
   end

   always_ff @(posedge i_clk) begin
      if (mem_we) mem_q[mem_idx] <= mem_d;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign o_busy = busy;
   assign o_err  = err_q;

endmodule

// File: tb/tb_nnrv_ram.sv
// Self-checking bench for nnrv_ram (DEPTH_LOG2=4); follows NNRV_RAM_CLEAR_EN.
module tb_nnrv_ram;

   localparam int DW = 64;
   localparam int MW = 8;
   localparam int XL = 64;
   localparam int DL = 4;
   localparam int NW = 16;
   localparam logic [63:0] LIMIT = 64'd128;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic [XL-1:0] i_rd_addr, i_wr_addr;
   logic          i_rd_en, i_wr_en;
   logic [MW-1:0] i_rd_mask, i_wr_mask;
   logic [DW-1:0] i_wr_data, o_rd_data;
   logic          o_busy, o_err;

   always #5 i_clk = ~i_clk;

   nnrv_ram #(
      .DATA_WIDTH (DW),
      .MASK_WIDTH (MW),
      .XLEN       (XL),
      .DEPTH_LOG2 (DL)
   ) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_rd_addr (i_rd_addr),
      .i_rd_en   (i_rd_en),
      .i_rd_mask (i_rd_mask),
      .o_rd_data (o_rd_data),
      .i_wr_addr (i_wr_addr),
      .i_wr_en   (i_wr_en),
      .i_wr_mask (i_wr_mask),
      .i_wr_data (i_wr_data),
      .o_busy    (o_busy),
      .o_err     (o_err)
   );

   logic [63:0] m_mem [NW];
   bit          m_err;
   int          m_left;
   int          checks = 0;
   int          errors = 0;
   logic [63:0] last_rd;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] exp_read(input logic en, input logic [63:0] addr,
                                            input logic [7:0] mask);
      logic [63:0] w, r;
      r = '0;
      if (!en || addr >= LIMIT || m_left > 0) return r;
      w = m_mem[addr[6:3]];
      for (int b = 0; b < 8; b++) if (mask[b]) r[b*8 +: 8] = w[b*8 +: 8];
      return r;
   endfunction

   task automatic cycle(input logic re, input logic [63:0] ra, input logic [7:0] rm,
                        input logic we, input logic [63:0] wa, input logic [7:0] wm,
                        input logic [63:0] wd, input string tag);
      i_rd_en = re; i_rd_addr = ra; i_rd_mask = rm;
      i_wr_en = we; i_wr_addr = wa; i_wr_mask = wm; i_wr_data = wd;
      #1;
      last_rd = o_rd_data;
      check({tag, " rd"}, o_rd_data, exp_read(re, ra, rm));
      check({tag, " busy"}, {63'd0, o_busy}, (m_left > 0) ? 64'd1 : 64'd0);
      @(posedge i_clk);
      if (re && ra >= LIMIT) m_err = 1'b1;
      if (we && m_left == 0) begin
         if (wa >= LIMIT) m_err = 1'b1;
         else for (int b = 0; b < 8; b++) if (wm[b]) m_mem[wa[6:3]][b*8 +: 8] = wd[b*8 +: 8];
      end
      if (m_left > 0) m_left--;
      #1;
      check({tag, " err"}, {63'd0, o_err}, {63'd0, m_err});
   endtask

   task automatic idle();
      cycle(1'b0, 64'd0, 8'h00, 1'b0, 64'd0, 8'h00, 64'd0, "idle");
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_rd_en = 1'b0; i_wr_en = 1'b0; i_rd_addr = '0; i_wr_addr = '0;
      i_rd_mask = '0; i_wr_mask = '0; i_wr_data = '0;
      m_err = 1'b0;
`ifdef NNRV_RAM_CLEAR_EN
      for (int w = 0; w < NW; w++) m_mem[w] = '0;
      m_left = NW;
`else
      m_left = 0;
`endif
      repeat (3) @(posedge i_clk);
      #1;
      check("rst err", {63'd0, o_err}, 64'd0);
      check("rst rd", o_rd_data, 64'd0);
      check("rst busy", {63'd0, o_busy}, (m_left > 0) ? 64'd1 : 64'd0);
      i_rst = 1'b0;
   endtask

   task automatic measure_busy(input string tag);
      int n;
      n = 0;
      while (o_busy === 1'b1 && n < 100) begin
         @(posedge i_clk);
         #1;
         n++;
      end
      check(tag, 64'(n), 64'd16);
      m_left = 0;
   endtask

   task automatic rand_ops(input int n, input string tag);
      for (int k = 0; k < n; k++)
         cycle($urandom_range(0, 1) == 1, 64'($urandom_range(0, 127)), 8'($urandom_range(0, 255)),
               $urandom_range(0, 1) == 1, 64'($urandom_range(0, 127)), 8'($urandom_range(0, 255)),
               {$urandom, $urandom}, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired after 200000 time units");
      $fatal(1);
   end

   initial begin
      do_reset();
`ifdef NNRV_RAM_CLEAR_EN
      measure_busy("clear_len");
      for (int w = 0; w < NW; w++) begin
         cycle(1'b1, 64'(w * 8), 8'hFF, 1'b0, 64'd0, 8'h00, 64'd0, "clr_word");
         check("clr_zero", last_rd, 64'd0);
      end
`else
      for (int w = 0; w < NW; w++)
         cycle(1'b0, 64'd0, 8'h00, 1'b1, 64'(w * 8), 8'hFF, {$urandom, $urandom}, "init_wr");
`endif
      // Lane merge: full write then low-lane overwrite, read back via 0x44.
      cycle(1'b0, 64'd0, 8'h00, 1'b1, 64'h40, 8'hFF, 64'h1122334455667788, "w40");
      cycle(1'b0, 64'd0, 8'h00, 1'b1, 64'h40, 8'h01, 64'hAAAAAAAAAAAAAAAA, "w40m");
      cycle(1'b1, 64'h44, 8'hFF, 1'b0, 64'd0, 8'h00, 64'd0, "r44");
      check("merge", last_rd, 64'h11223344556677AA);

      cycle(1'b0, 64'd0, 8'h00, 1'b1, 64'h08, 8'hFF, 64'hDEADBEEFCAFEF00D, "w08");
      cycle(1'b1, 64'h08, 8'h0F, 1'b0, 64'd0, 8'h00, 64'd0, "r08");
      check("rd_mask", last_rd, 64'h00000000CAFEF00D);

      cycle(1'b0, 64'd0, 8'h00, 1'b1, 64'h10, 8'hFF, 64'h3, "w10");
      cycle(1'b1, 64'h10, 8'hFF, 1'b1, 64'h10, 8'hFF, 64'h5, "rw10");
      check("rw_old", last_rd, 64'h3);
      cycle(1'b1, 64'h10, 8'hFF, 1'b0, 64'd0, 8'h00, 64'd0, "r10");
      check("rw_new", last_rd, 64'h5);

      rand_ops(150, "rand");

      cycle(1'b1, 64'h1000, 8'hFF, 1'b0, 64'd0, 8'h00, 64'd0, "oor_rd");
      check("oor_rd_err", {63'd0, o_err}, 64'd1);
      do_reset();
`ifdef NNRV_RAM_CLEAR_EN
      measure_busy("clear_len2");
`endif
      cycle(1'b1, 64'h08, 8'hFF, 1'b0, 64'd0, 8'h00, 64'd0, "after_rst");

      cycle(1'b0, 64'd0, 8'h00, 1'b1, 64'h80, 8'hFF, {$urandom, $urandom}, "oor_wr");
      check("oor_wr_err", {63'd0, o_err}, 64'd1);
      repeat (3) idle();
      check("err_held", {63'd0, o_err}, 64'd1);
      cycle(1'b1, 64'h00, 8'hFF, 1'b0, 64'd0, 8'h00, 64'd0, "w0_intact");
      do_reset();
`ifdef NNRV_RAM_CLEAR_EN
      // Interrupt the clear at count 7, writes issued meanwhile must be dropped.
      rand_ops(7, "mid_clear");
      i_rst = 1'b1;
      #1;
      check("mid_rst busy", {63'd0, o_busy}, 64'd1);
      @(posedge i_clk);
      #1;
      m_err = 1'b0;
      m_left = NW;
      for (int w = 0; w < NW; w++) m_mem[w] = '0;
      i_rst = 1'b0;
      measure_busy("restart_len");
      for (int w = 0; w < NW; w++) begin
         cycle(1'b1, 64'(w * 8), 8'hFF, 1'b0, 64'd0, 8'h00, 64'd0, "restart_word");
         check("restart_zero", last_rd, 64'd0);
      end
`else
      check("no_busy", {63'd0, o_busy}, 64'd0);
`endif
      rand_ops(40, "rand2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
